// File: rtl/dpram_fifo_pkg.sv
// Shared constants and width helpers for the dpram-backed first-word-fall-through FIFO.
package dpram_fifo_pkg;

  localparam int FIFO_SKID_DEPTH = 2;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  // Count spans 0 .. 2**AW + FIFO_SKID_DEPTH inclusive.
  function automatic int count_width(input int aw);
    return clog2((1 << aw) + FIFO_SKID_DEPTH + 1);
  endfunction

endpackage

// File: rtl/dpram.sv
// True dual-port RAM with registered read on port B; inferred as block RAM, contents never reset.
module dpram #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clock,
  input  logic [AW-1:0] address_a,
  input  logic [DW-1:0] data_a,
  input  logic          wren_a,
  input  logic          enable_a,
  input  logic          cs_a,
  input  logic [AW-1:0] address_b,
  input  logic [DW-1:0] data_b,
  input  logic          wren_b,
  input  logic          enable_b,
  input  logic          cs_b,
  output logic [DW-1:0] q_b
);

  logic [DW-1:0] mem [0:(1 << AW)-1];

  always_ff @(posedge clock) begin
    if (enable_a && cs_a && wren_a) begin
      mem[address_a] <= data_a;
    end
    if (enable_b && cs_b) begin
      if (wren_b) begin
        mem[address_b] <= data_b;
      end
      q_b <= mem[address_b];
    end
  end

endmodule

// File: rtl/dpram_fifo.sv
// FWFT FIFO on top of dpram; a 2-entry skid buffer hides the RAM read latency for 1 word/cycle.
module dpram_fifo
  import dpram_fifo_pkg::*;
#(
  parameter int  AW       = 8,
  parameter int  DW       = 8,
  parameter int  AF_LEVEL = (1 << AW) - 2,
  localparam int CW       = count_width(AW)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          flush,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [DW-1:0] wr_data,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [DW-1:0] rd_data,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          almost_full,
  output logic          overflow
);

  localparam logic [AW:0] RAM_FULL = (AW+1)'(1 << AW);

  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [AW:0]   ram_cnt_reg, ram_cnt_next;
  logic          inflight_reg, inflight_next;
  logic [1:0]    skid_occ_reg, skid_occ_next, occ_after_pop;
  logic [DW-1:0] skid0_reg, skid0_next;
  logic [DW-1:0] skid1_reg, skid1_next;
  logic [CW-1:0] count_reg, count_next;
  logic          overflow_reg, overflow_next;
  logic          push, pop, issue;
  logic [DW-1:0] q_b;

  assign wr_ready = (ram_cnt_reg != RAM_FULL) && !flush;
  assign push     = wr_valid && wr_ready;
  assign rd_valid = (skid_occ_reg != 2'd0);
  assign pop      = rd_valid && rd_ready && !flush;

  // Issue only if the word can still land in the skid after the in-flight one returns.
  assign issue = (ram_cnt_reg != '0) && !flush &&
                 (({1'b0, skid_occ_reg} + {2'b00, inflight_reg} - {2'b00, pop})
                   < 3'(FIFO_SKID_DEPTH));

  assign rd_data     = skid0_reg;
  assign count       = count_reg;
  assign empty       = (count_reg == '0);
  assign almost_full = (count_reg >= CW'(AF_LEVEL));
  assign overflow    = overflow_reg;

  dpram #(
    .AW(AW),
    .DW(DW)
  ) u_ram (
    .clock    (clock),
    .address_a(wr_ptr_reg),
    .data_a   (wr_data),
    .wren_a   (push),
    .enable_a (1'b1),
    .cs_a     (1'b1),
    .address_b(rd_ptr_reg),
    .data_b   ({DW{1'b0}}),
    .wren_b   (1'b0),
    .enable_b (1'b1),
    .cs_b     (1'b1),
    .q_b      (q_b)
  );

  always_comb begin
    wr_ptr_next   = wr_ptr_reg;
    rd_ptr_next   = rd_ptr_reg;
    ram_cnt_next  = ram_cnt_reg;
    inflight_next = inflight_reg;
    skid_occ_next = skid_occ_reg;
    skid0_next    = skid0_reg;
    skid1_next    = skid1_reg;
    count_next    = count_reg;
    overflow_next = overflow_reg;
    occ_after_pop = skid_occ_reg - {1'b0, pop};

    if (flush) begin
      wr_ptr_next   = '0;
      rd_ptr_next   = '0;
      ram_cnt_next  = '0;
      inflight_next = 1'b0;
      skid_occ_next = 2'd0;
      count_next    = '0;
      overflow_next = 1'b0;
    end else begin
      if (push) wr_ptr_next = wr_ptr_reg + 1'b1;
      if (issue) rd_ptr_next = rd_ptr_reg + 1'b1;
      inflight_next = issue;
      ram_cnt_next  = ram_cnt_reg + {{AW{1'b0}}, push} - {{AW{1'b0}}, issue};
      count_next    = count_reg + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};

      if (pop) skid0_next = skid1_reg;
      // Returning word goes to the first slot left free after this edge's pop.
      if (inflight_reg) begin
        if (occ_after_pop == 2'd0) skid0_next = q_b;
        else skid1_next = q_b;
      end
      skid_occ_next = occ_after_pop + {1'b0, inflight_reg};

      if (wr_valid && !wr_ready) overflow_next = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      ram_cnt_reg  <= '0;
      inflight_reg <= 1'b0;
      skid_occ_reg <= 2'd0;
      skid0_reg    <= '0;
      skid1_reg    <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      ram_cnt_reg  <= ram_cnt_next;
      inflight_reg <= inflight_next;
      skid_occ_reg <= skid_occ_next;
      skid0_reg    <= skid0_next;
      skid1_reg    <= skid1_next;
      count_reg    <= count_next;
      overflow_reg <= overflow_next;
    end
  end

endmodule

// File: tb/tb_dpram_fifo.sv
// Self-checking bench for dpram_fifo (AW=2): vector table, directed corner sequences, queue-model random run.
module tb_dpram_fifo;
  import dpram_fifo_pkg::*;

  localparam int AW = 2;
  localparam int DW = 8;
  localparam int CW = count_width(AW);

  logic          clk;
  logic          reset_n;
  logic          flush;
  logic          wr_valid;
  logic          wr_ready;
  logic [DW-1:0] wr_data;
  logic          rd_valid;
  logic          rd_ready;
  logic [DW-1:0] rd_data;
  logic [CW-1:0] count;
  logic          empty;
  logic          almost_full;
  logic          overflow;

  dpram_fifo #(
    .AW(AW),
    .DW(DW)
  ) dut (
    .clock      (clk),
    .reset_n    (reset_n),
    .flush      (flush),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_data    (wr_data),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .rd_data    (rd_data),
    .count      (count),
    .empty      (empty),
    .almost_full(almost_full),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       wv;
    logic [7:0] wd;
    logic       rr;
    logic       fl;
    logic       e_rv;
    logic [7:0] e_data;
    int         e_cnt;
    logic       e_wrr;
    logic       e_af;
    logic       e_ovf;
  } vec_t;

  vec_t       vecs[13];
  int         n_checks;
  int         n_fail;
  logic [7:0] q[$];
  logic       ovf_m;
  logic [7:0] last_pop;
  int         n_popped;
  logic       pushed;
  int         word;
  int         base;
  int         cycles;
  logic       seen;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus against the queue model; called right after a falling edge.
  task automatic cyc(input logic wv, input logic [7:0] wd, input logic rr, input logic fl,
                     output logic did_push);
    logic pop;
    wr_valid = wv;
    wr_data  = wd;
    rd_ready = rr;
    flush    = fl;
    #1;
    did_push = wv && wr_ready;
    pop      = rd_valid && rr && !fl;
    if (fl) check("wr_ready_during_flush", {31'b0, wr_ready}, 32'd0);
    else if (q.size() < 4) check("wr_ready_not_full", {31'b0, wr_ready}, 32'd1);
    if (q.size() == 6) check("wr_ready_full", {31'b0, wr_ready}, 32'd0);
    if (rd_valid) begin
      if (q.size() == 0) check("rd_valid_with_model_empty", {31'b0, rd_valid}, 32'd0);
      else check("rd_data_head", {24'b0, rd_data}, {24'b0, q[0]});
    end
    if (wv && !wr_ready && !fl) ovf_m = 1'b1;
    @(posedge clk);
    if (fl) begin
      q.delete();
      ovf_m = 1'b0;
    end else begin
      if (pop && q.size() > 0) begin
        last_pop = q.pop_front();
        n_popped++;
      end
      if (did_push) q.push_back(wd);
    end
    @(negedge clk);
    check("count", {{(32-CW){1'b0}}, count}, q.size());
    check("empty", {31'b0, empty}, {31'b0, (q.size() == 0)});
    check("almost_full", {31'b0, almost_full}, {31'b0, (q.size() >= 2)});
    check("overflow", {31'b0, overflow}, {31'b0, ovf_m});
  endtask

  task automatic idle_cycle();
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    flush    = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wr_ready"}, {31'b0, wr_ready}, 32'd1);
    check({tag, "_rd_valid"}, {31'b0, rd_valid}, 32'd0);
    check({tag, "_rd_data"}, {24'b0, rd_data}, 32'd0);
    check({tag, "_count"}, {{(32-CW){1'b0}}, count}, 32'd0);
    check({tag, "_empty"}, {31'b0, empty}, 32'd1);
    check({tag, "_almost_full"}, {31'b0, almost_full}, 32'd0);
    check({tag, "_overflow"}, {31'b0, overflow}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    n_popped = 0;
    ovf_m    = 1'b0;
    reset_n  = 1'b0;
    flush    = 1'b0;
    wr_valid = 1'b0;
    wr_data  = '0;
    rd_ready = 1'b0;

    // Fill to full with rd_ready low, overflow on the 7th attempt, then drain in order.
    vecs[0]  = '{1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 8'h00, 1, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 8'h00, 2, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 8'h03, 1'b0, 1'b0, 1'b1, 8'h01, 3, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 8'h04, 1'b0, 1'b0, 1'b1, 8'h01, 4, 1'b1, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 8'h05, 1'b0, 1'b0, 1'b1, 8'h01, 5, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 8'h06, 1'b0, 1'b0, 1'b1, 8'h01, 6, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 8'h07, 1'b0, 1'b0, 1'b1, 8'h01, 6, 1'b0, 1'b1, 1'b1};
    vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h02, 5, 1'b1, 1'b1, 1'b1};
    vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h03, 4, 1'b1, 1'b1, 1'b1};
    vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h04, 3, 1'b1, 1'b1, 1'b1};
    vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h05, 2, 1'b1, 1'b1, 1'b1};
    vecs[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h06, 1, 1'b1, 1'b0, 1'b1};
    vecs[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b1, 1'b0, 1'b1};

    // Reset values
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    reset_n = 1'b1;
    @(negedge clk);
    $display("reset released: count=%0d empty=%0b wr_ready=%0b", count, empty, wr_ready);

    // Single word latency: push at edge 1, visible after edge 3, popped at edge 4
    wr_valid = 1'b1; wr_data = 8'h11; rd_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    wr_valid = 1'b0;
    check("single_cnt_e1", {{(32-CW){1'b0}}, count}, 32'd1);
    check("single_rv_e1", {31'b0, rd_valid}, 32'd0);
    @(posedge clk); @(negedge clk);
    check("single_rv_e2", {31'b0, rd_valid}, 32'd0);
    @(posedge clk); @(negedge clk);
    check("single_rv_e3", {31'b0, rd_valid}, 32'd1);
    check("single_data_e3", {24'b0, rd_data}, 32'h11);
    check("single_cnt_e3", {{(32-CW){1'b0}}, count}, 32'd1);
    @(posedge clk); @(negedge clk);
    check("single_cnt_e4", {{(32-CW){1'b0}}, count}, 32'd0);
    check("single_empty_e4", {31'b0, empty}, 32'd1);
    check("single_rv_e4", {31'b0, rd_valid}, 32'd0);
    $display("single word: rd_valid latency checked, data 0x11");

    // Vector table
    for (int i = 0; i < 13; i++) begin
      wr_valid = vecs[i].wv;
      wr_data  = vecs[i].wd;
      rd_ready = vecs[i].rr;
      flush    = vecs[i].fl;
      @(posedge clk); @(negedge clk);
      check($sformatf("vec%0d_rd_valid", i), {31'b0, rd_valid}, {31'b0, vecs[i].e_rv});
      if (vecs[i].e_rv) check($sformatf("vec%0d_rd_data", i), {24'b0, rd_data}, {24'b0, vecs[i].e_data});
      check($sformatf("vec%0d_count", i), {{(32-CW){1'b0}}, count}, vecs[i].e_cnt);
      check($sformatf("vec%0d_wr_ready", i), {31'b0, wr_ready}, {31'b0, vecs[i].e_wrr});
      check($sformatf("vec%0d_almost_full", i), {31'b0, almost_full}, {31'b0, vecs[i].e_af});
      check($sformatf("vec%0d_overflow", i), {31'b0, overflow}, {31'b0, vecs[i].e_ovf});
      $display("vec %0d: wv=%0b wd=%02h rr=%0b -> rv=%0b data=%02h count=%0d wr_ready=%0b af=%0b ovf=%0b",
               i, vecs[i].wv, vecs[i].wd, vecs[i].rr, rd_valid, rd_data, count, wr_ready,
               almost_full, overflow);
    end
    idle_cycle();

    // Flush at count 5 with a read in flight; overflow still set from the table
    q.delete();
    ovf_m = 1'b1;
    for (int i = 0; i < 7; i++) cyc(1'b1, 8'h30 + 8'(i), 1'b0, 1'b0, pushed);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, pushed);
    check("flush_pre_count", {{(32-CW){1'b0}}, count}, 32'd5);
    cyc(1'b1, 8'h55, 1'b1, 1'b1, pushed);
    check("flush_rd_valid", {31'b0, rd_valid}, 32'd0);
    check("flush_count", {{(32-CW){1'b0}}, count}, 32'd0);
    check("flush_overflow", {31'b0, overflow}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 8'h00, 1'b0, 1'b0, pushed);
      check("flush_no_stale", {31'b0, rd_valid}, 32'd0);
    end
    base = n_popped;
    cyc(1'b1, 8'hAA, 1'b1, 1'b0, pushed);
    for (int i = 0; i < 6; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0, pushed);
    check("flush_next_word_count", n_popped - base, 32'd1);
    check("flush_next_word", {24'b0, last_pop}, 32'hAA);
    $display("flush: next word out 0x%02h", last_pop);

    // Streaming 0..99 with continuous valid/ready
    base = n_popped; word = 0; seen = 1'b0; cycles = 0;
    while ((word < 100 || q.size() > 0) && cycles < 400) begin
      cyc(word < 100, 8'(word), 1'b1, 1'b0, pushed);
      if (pushed) word++;
      if (rd_valid) seen = 1'b1;
      if (seen && (n_popped - base) < 100) check("stream_no_bubble", {31'b0, rd_valid}, 32'd1);
      check("stream_count_le3", {31'b0, (count <= CW'(3))}, 32'd1);
      cycles++;
    end
    check("stream_words_out", n_popped - base, 32'd100);
    check("stream_last_word", {24'b0, last_pop}, 32'd99);
    $display("stream: %0d words out in %0d cycles", n_popped - base, cycles);

    // Random backpressure
    base = n_popped; word = 0; cycles = 0;
    while ((word < 1000 || q.size() > 0) && cycles < 20000) begin
      cyc((word < 1000) && ($urandom_range(0, 99) < 60), 8'($urandom_range(0, 255)),
          $urandom_range(0, 99) < 50, 1'b0, pushed);
      if (pushed) word++;
      cycles++;
    end
    check("random_words_out", n_popped - base, 32'd1000);
    $display("random: %0d words out in %0d cycles", n_popped - base, cycles);

    // Async reset between clock edges while full and overflowed
    for (int i = 0; i < 7; i++) cyc(1'b1, 8'h70 + 8'(i), 1'b0, 1'b0, pushed);
    #2;
    reset_n = 1'b0;
    wr_valid = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    @(posedge clk); @(negedge clk);
    reset_n = 1'b1;
    q.delete();
    ovf_m = 1'b0;
    base = n_popped; word = 0; cycles = 0;
    while ((word < 10 || q.size() > 0) && cycles < 100) begin
      cyc(word < 10, 8'hC0 + 8'(word), 1'b1, 1'b0, pushed);
      if (pushed) word++;
      cycles++;
    end
    check("post_reset_words_out", n_popped - base, 32'd10);
    check("post_reset_last_word", {24'b0, last_pop}, 32'hC9);
    $display("async reset: recovered, %0d words out", n_popped - base);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
